// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period/high-time meter.
package period_meter_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Saturation value at the default counter width
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous input plus a rising-edge pulse
// on the synchronized signal.
module sync_edge_det
    import period_meter_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic sig_s_o,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q;
    logic              sig_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], sig_i};
            sig_d_q <= sync_q[STAGES-1];
        end
    end

    assign sig_s_o = sync_q[STAGES-1];
    // Combinational so the FSM acts in the same cycle the edge becomes visible
    assign rise_c  = sync_q[STAGES-1] & ~sig_d_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous signal in clk cycles and
// offers each result through a single-entry valid/ready register.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overflow,
    output logic             overrun,
    output logic             busy
);

    // All-ones at this instance's width
    localparam logic [CNT_W-1:0] CNT_LIM = {CNT_W{CNT_MAX[0]}};

    logic sig_s;
    logic rise;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_i   (sig_in),
        .sig_s_o (sig_s),
        .rise_c  (rise)
    );

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hi_q,     hi_d;
    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic             ovf_q,    ovf_d;
    logic             ovr_q,    ovr_d;
    logic             busy_q,   busy_d;

    logic             cap;
    logic [CNT_W-1:0] cap_period;
    logic [CNT_W-1:0] cap_high;
    logic             cap_ovf;
    logic [CNT_W-1:0] hi_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        valid_d    = valid_q;
        period_d   = period_q;
        high_d     = high_q;
        ovf_d      = ovf_q;
        ovr_d      = ovr_q;
        busy_d     = busy_q;
        cap        = 1'b0;
        cap_period = cnt_q;
        cap_high   = hi_q;
        cap_ovf    = 1'b0;
        hi_inc     = (hi_q == CNT_LIM) ? hi_q : hi_q + CNT_W'(sig_s);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                hi_d  = '0;
                if (en) state_d = ST_ARM;
            end
            ST_ARM: begin
                // First edge only opens the window; it has no predecessor
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    hi_d    = CNT_W'(1);
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    cap   = 1'b1;
                    cnt_d = CNT_W'(1);
                    hi_d  = CNT_W'(1);
                end else if (cnt_q == CNT_LIM) begin
                    cap        = 1'b1;
                    cap_period = CNT_LIM;
                    cap_ovf    = 1'b1;
                    cnt_d      = '0;
                    hi_d       = '0;
                    state_d    = ST_ARM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    hi_d  = hi_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Result register: load when empty or being drained this cycle
        if (cap) begin
            if (!valid_q || meas_ready) begin
                valid_d  = 1'b1;
                period_d = cap_period;
                high_d   = cap_high;
                ovf_d    = cap_ovf;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end

        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hi_d     = '0;
            valid_d  = 1'b0;
            period_d = '0;
            high_d   = '0;
            ovf_d    = 1'b0;
            ovr_d    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            valid_q  <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            high_q   <= high_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
        end
    end

    assign meas_valid = valid_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign overflow   = ovf_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter at CNT_W=8 so saturation is reachable quickly.
module tb_period_meter;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sig_in;
    logic          meas_ready;
    logic          meas_valid;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          overflow;
    logic          overrun;
    logic          busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   wp = 0;
    int   wh = 0;
    int   ph = 0;
    int   n;
    logic seen;

    always #5 clk = ~clk;

    period_meter #(
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .period     (period),
        .high_time  (high_time),
        .overflow   (overflow),
        .overrun    (overrun),
        .busy       (busy)
    );

    // One clk cycle; inputs change and outputs are sampled 1 time unit after posedge
    task automatic step();
        @(posedge clk);
        #1;
        if (wp != 0) begin
            ph     = (ph + 1) % wp;
            sig_in = (ph < wh);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int p, input int h, input int o);
        chk({tag, "_period"},   32'(period),    32'(p));
        chk({tag, "_high"},     32'(high_time), 32'(h));
        chk({tag, "_overflow"}, 32'(overflow),  32'(o));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},    32'(meas_valid), 32'd0);
        chk({tag, "_period"},   32'(period),     32'd0);
        chk({tag, "_high"},     32'(high_time),  32'd0);
        chk({tag, "_overflow"}, 32'(overflow),   32'd0);
        chk({tag, "_overrun"},  32'(overrun),    32'd0);
        chk({tag, "_busy"},     32'(busy),       32'd0);
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (meas_valid !== 1'b1 && cnt < budget);
        chk("wait_valid", 32'(meas_valid), 32'd1);
    endtask

    task automatic flush();
        en     = 1'b0;
        wp     = 0;
        sig_in = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        sig_in     = 1'b0;
        meas_ready = 1'b0;
        repeat (3) step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // Divide-by-2 input, always ready
        en = 1'b1; meas_ready = 1'b1; wp = 2; wh = 1; ph = 1;
        wait_valid(20, n);
        chk("div2_latency", 32'(n), 32'd6);
        chk_res("div2_a", 2, 1, 0);
        wait_valid(10, n);
        chk("div2_gap", 32'(n), 32'd2);
        chk_res("div2_b", 2, 1, 0);

        flush();
        chk("en_low_valid", 32'(meas_valid), 32'd0);
        chk("en_low_busy",  32'(busy),       32'd0);

        // Period 8, high 3; first edge silent, then one-cycle valid pulses
        wp = 8; wh = 3; ph = 7; en = 1'b1; meas_ready = 1'b1; seen = 1'b0;
        repeat (8) begin
            step();
            seen |= meas_valid;
        end
        chk("p8_first_edge_silent", 32'(seen), 32'd0);
        chk("p8_busy", 32'(busy), 32'd1);
        wait_valid(20, n);
        chk("p8_latency", 32'(n), 32'd4);
        chk_res("p8_a", 8, 3, 0);
        step();
        chk("p8_pulse", 32'(meas_valid), 32'd0);
        wait_valid(20, n);
        chk("p8_gap", 32'(n), 32'd7);
        chk_res("p8_b", 8, 3, 0);

        flush();

        // Period 4, consumer stalled: result held, later ones dropped
        wp = 4; wh = 2; ph = 3; en = 1'b1; meas_ready = 1'b0;
        repeat (20) step();
        chk("ovr_held_valid", 32'(meas_valid), 32'd1);
        chk_res("ovr_held", 4, 2, 0);
        chk("ovr_flag", 32'(overrun), 32'd1);
        meas_ready = 1'b1;
        step();
        chk("ovr_consumed", 32'(meas_valid), 32'd0);
        wait_valid(10, n);
        chk("ovr_next_latency", 32'(n), 32'd3);
        chk_res("ovr_next", 4, 2, 0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        en = 1'b0;
        step();
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_en_low_valid", 32'(meas_valid), 32'd0);

        flush();

        // Capture in the same cycle as a handshake
        en = 1'b1; meas_ready = 1'b0;
        for (int s = 1; s <= 15; s++) begin
            step();
            sig_in = (s == 1 || s == 2 || s == 5 || s == 6 || s == 11 || s == 12);
            if (s == 8) begin
                chk("sim_first_valid", 32'(meas_valid), 32'd1);
                chk_res("sim_first", 4, 2, 0);
            end
            if (s == 13) meas_ready = 1'b1;
            if (s == 14) begin
                chk("sim_reload_valid", 32'(meas_valid), 32'd1);
                chk_res("sim_reload", 6, 2, 0);
                chk("sim_no_overrun", 32'(overrun), 32'd0);
            end
            if (s == 15) chk("sim_drained", 32'(meas_valid), 32'd0);
        end

        flush();

        // Single edge then constant low: saturate at 255
        en = 1'b1; meas_ready = 1'b0;
        step(); sig_in = 1'b1;
        step();
        step(); sig_in = 1'b0;
        wait_valid(400, n);
        chk("sat_latency", 32'(n), 32'd256);
        chk_res("sat", 255, 2, 1);
        chk("sat_busy_arm", 32'(busy), 32'd1);
        meas_ready = 1'b1; seen = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            sig_in = (t == 1 || t == 6);
            if (t >= 2 && t <= 8) seen |= meas_valid;
            if (t == 9) begin
                chk("sat_rearm_valid", 32'(meas_valid), 32'd1);
                chk_res("sat_rearm", 5, 1, 0);
            end
        end
        chk("sat_rearm_first_silent", 32'(seen), 32'd0);

        flush();

        // en dropped mid-measurement at cnt=5 with a held result and overrun
        en = 1'b1; meas_ready = 1'b0; wp = 4; wh = 2; ph = 3;
        repeat (16) step();
        wp = 0; sig_in = 1'b0;
        chk("endrop_pre_valid",   32'(meas_valid), 32'd1);
        chk("endrop_pre_overrun", 32'(overrun),    32'd1);
        repeat (4) step();
        en = 1'b0;
        step();
        chk_zero("endrop");
        en = 1'b1; seen = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            step();
            sig_in = (t == 1 || t == 2);
            seen |= meas_valid;
        end
        chk("endrop_first_silent", 32'(seen), 32'd0);
        chk("endrop_busy", 32'(busy), 32'd1);

        flush();

        // Reset pulsed mid-measurement at cnt=5
        en = 1'b1; meas_ready = 1'b0;
        for (int s = 1; s <= 12; s++) begin
            step();
            sig_in = (s == 1 || s == 5);
        end
        chk("rst_pre_valid", 32'(meas_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        step();
        rst_n = 1'b1; seen = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            sig_in = (t == 2 || t == 7);
            if (t <= 9) seen |= meas_valid;
            if (t == 10) begin
                chk("rst_after_valid", 32'(meas_valid), 32'd1);
                chk_res("rst_after", 5, 1, 0);
            end
        end
        chk("rst_first_silent", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
